// File: rtl/cpu_state_sequencer_pkg.sv
// Shared codes for the multi-cycle CPU: sequencer states and the default halt address.
package cpu_state_sequencer_pkg;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC1  = 2'd1,
    EXEC2  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [31:0] HALT_ADDR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/cpu_state_sequencer_if.sv
// Bundle between the state sequencer (slave side) and the CPU wrapper / memory / decode logic.
interface cpu_state_sequencer_if #(
  parameter int CNT_W = 32
);
  import cpu_state_sequencer_pkg::*;

  logic             ram_waitrequest_i;
  logic             mem_access_i;
  logic             muldiv_busy_i;
  logic [31:0]      pc_next_i;
  state_t           state_o;
  logic             advance_o;
  logic             commit_o;
  logic             active_o;
  logic             fault_o;
  logic [CNT_W-1:0] cycle_count_o;
  logic [CNT_W-1:0] stall_count_o;
  logic [CNT_W-1:0] retired_count_o;

  modport master (
    output ram_waitrequest_i, mem_access_i, muldiv_busy_i, pc_next_i,
    input  state_o, advance_o, commit_o, active_o, fault_o,
    input  cycle_count_o, stall_count_o, retired_count_o
  );

  modport slave (
    input  ram_waitrequest_i, mem_access_i, muldiv_busy_i, pc_next_i,
    output state_o, advance_o, commit_o, active_o, fault_o,
    output cycle_count_o, stall_count_o, retired_count_o
  );

endinterface

// File: rtl/cpu_state_sequencer_perf_counter.sv
// Free-running performance counter with synchronous clear and count enable; wraps modulo 2^CNT_W.
module cpu_state_sequencer_perf_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  output logic [CNT_W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cpu_state_sequencer.sv
// FETCH -> EXEC1 -> EXEC2 state register for the multi-cycle CPU, with memory/muldiv stalls,
// halt-on-address, a waitrequest watchdog and performance counters.
module cpu_state_sequencer
  import cpu_state_sequencer_pkg::*;
#(
  parameter logic [31:0] HALT_ADDR    = HALT_ADDR_DEFAULT,
  parameter int          WAIT_TIMEOUT = 1024,
  parameter int          CNT_W        = 32
) (
  input logic                  clk,
  input logic                  reset,
  cpu_state_sequencer_if.slave bus
);

  localparam int              WAIT_W      = $clog2(WAIT_TIMEOUT + 2);
  localparam bit              WATCHDOG_EN = (WAIT_TIMEOUT > 0);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WATCHDOG_EN ? WAIT_W'(WAIT_TIMEOUT - 1) : '0;

  state_t            state;
  state_t            state_next;
  logic              active;
  logic              fault;
  logic [WAIT_W-1:0] wait_cnt;
  logic              wait_stall;
  logic              busy_stall;
  logic              advance;
  logic              commit;
  logic              stalled;
  logic              timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= FETCH;
      active <= 1'b0;
    end else begin
      state  <= state_next;
      active <= (state_next != HALTED);
    end
  end

  // Timeout fires on the stalled cycle that would bring the count up to WAIT_TIMEOUT.
  always_comb begin
    state_next = state;
    if (timeout) begin
      state_next = HALTED;
    end else if (advance) begin
      case (state)
        FETCH:   state_next = EXEC1;
        EXEC1:   state_next = EXEC2;
        EXEC2:   state_next = (bus.pc_next_i == HALT_ADDR) ? HALTED : FETCH;
        default: state_next = state;
      endcase
    end
  end

  always_comb begin
    wait_stall = 1'b0;
    busy_stall = 1'b0;
    case (state)
      FETCH:   wait_stall = bus.ram_waitrequest_i;
      EXEC1: begin
        wait_stall = bus.mem_access_i & bus.ram_waitrequest_i;
        busy_stall = bus.muldiv_busy_i;
      end
      EXEC2:   wait_stall = bus.mem_access_i & bus.ram_waitrequest_i;
      default: wait_stall = 1'b0;
    endcase
    advance = active & (state != HALTED) & ~wait_stall & ~busy_stall;
    commit  = advance & (state == EXEC2);
    stalled = active & ~advance;
    timeout = WATCHDOG_EN & active & wait_stall & (wait_cnt == WAIT_LAST);
  end

  // Muldiv-only stalls hold the watchdog count rather than clearing or advancing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      fault    <= 1'b0;
      wait_cnt <= '0;
    end else begin
      if (timeout) begin
        fault <= 1'b1;
      end
      if (advance) begin
        wait_cnt <= '0;
      end else if (active & wait_stall) begin
        wait_cnt <= wait_cnt + 1'b1;
      end
    end
  end

  cpu_state_sequencer_perf_counter #(.CNT_W(CNT_W)) u_cycle_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (active),
    .count (bus.cycle_count_o)
  );

  cpu_state_sequencer_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (stalled),
    .count (bus.stall_count_o)
  );

  cpu_state_sequencer_perf_counter #(.CNT_W(CNT_W)) u_retired_cnt (
    .clk   (clk),
    .clear (reset),
    .en    (commit),
    .count (bus.retired_count_o)
  );

  assign bus.state_o   = state;
  assign bus.advance_o = advance;
  assign bus.commit_o  = commit;
  assign bus.active_o  = active;
  assign bus.fault_o   = fault;

endmodule

// File: tb/tb_cpu_state_sequencer.sv
// Directed and randomized checks of cpu_state_sequencer against an instruction-level reference model.
module tb_cpu_state_sequencer;
  import cpu_state_sequencer_pkg::*;

  localparam logic [31:0] HALT = 32'h0000_0000;
  localparam int          TO   = 8;

  logic clk = 1'b0;
  logic reset;

  cpu_state_sequencer_if #(.CNT_W(32)) bus ();

  cpu_state_sequencer #(
    .HALT_ADDR    (HALT),
    .WAIT_TIMEOUT (TO),
    .CNT_W        (32)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: where the current instruction is, plus the counters it implies.
  state_t      m_state  = FETCH;
  bit          m_active = 1'b0;
  bit          m_fault  = 1'b0;
  int unsigned m_cyc    = 0;
  int unsigned m_stall  = 0;
  int unsigned m_ret    = 0;
  int unsigned m_wd     = 0;

  function automatic bit m_mem_blocked();
    bit needs_mem;
    needs_mem = (m_state == FETCH) || (bus.mem_access_i == 1'b1);
    return needs_mem && (bus.ram_waitrequest_i == 1'b1);
  endfunction

  function automatic bit m_adv();
    bit busy_block;
    busy_block = (m_state == EXEC1) && (bus.muldiv_busy_i == 1'b1);
    return m_active && (m_state != HALTED) && !m_mem_blocked() && !busy_block;
  endfunction

  function automatic bit m_commit();
    return m_adv() && (m_state == EXEC2);
  endfunction

  task automatic model_step();
    bit adv;
    if (reset) begin
      m_state = FETCH; m_active = 1'b0; m_fault = 1'b0;
      m_cyc = 0; m_stall = 0; m_ret = 0; m_wd = 0;
    end else if (m_active) begin
      adv = m_adv();
      m_cyc++;
      if (!adv) m_stall++;
      if (adv) begin
        m_wd = 0;
        if (m_state == EXEC2) begin
          m_ret++;
          m_state = (bus.pc_next_i == HALT) ? HALTED : FETCH;
        end else begin
          m_state = (m_state == FETCH) ? EXEC1 : EXEC2;
        end
      end else if (m_mem_blocked()) begin
        m_wd++;
        if (m_wd == TO) begin
          m_fault = 1'b1;
          m_state = HALTED;
        end
      end
      m_active = (m_state != HALTED);
    end else if (m_state != HALTED) begin
      m_active = 1'b1;
    end
  endtask

  task automatic drive(input bit r, input bit wr, input bit mem, input bit busy, input logic [31:0] pc);
    reset                 = r;
    bus.ram_waitrequest_i = wr;
    bus.mem_access_i      = mem;
    bus.muldiv_busy_i     = busy;
    bus.pc_next_i         = pc;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    tick();
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h1234);
    tick();
    tick();
    #2;
    checks++; if (bus.state_o !== FETCH) begin failures++; $display("FAIL reset_state got=%0d want=%0d", bus.state_o, FETCH); end
    checks++; if (bus.active_o !== 1'b0) begin failures++; $display("FAIL reset_active got=%0b want=0", bus.active_o); end
    checks++; if (bus.fault_o !== 1'b0) begin failures++; $display("FAIL reset_fault got=%0b want=0", bus.fault_o); end
    checks++; if (bus.cycle_count_o !== 32'd0) begin failures++; $display("FAIL reset_cycles got=%0d want=0", bus.cycle_count_o); end
    checks++; if (bus.stall_count_o !== 32'd0) begin failures++; $display("FAIL reset_stalls got=%0d want=0", bus.stall_count_o); end
    checks++; if (bus.retired_count_o !== 32'd0) begin failures++; $display("FAIL reset_retired got=%0d want=0", bus.retired_count_o); end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    #2;
    checks++; if (bus.advance_o !== 1'b0) begin failures++; $display("FAIL reset_idle_advance got=%0b want=0", bus.advance_o); end
    tick();
    #2;
    checks++; if (bus.active_o !== 1'b1) begin failures++; $display("FAIL reset_release_active got=%0b want=1", bus.active_o); end
  endtask

  task automatic test_no_wait();
    state_t seq [3] = '{FETCH, EXEC1, EXEC2};
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 32'h100);
      #2;
      checks++; if (bus.state_o !== seq[i % 3]) begin failures++; $display("FAIL seq_state cyc=%0d got=%0d want=%0d", i + 1, bus.state_o, seq[i % 3]); end
      checks++; if (bus.commit_o !== ((i % 3) == 2)) begin failures++; $display("FAIL seq_commit cyc=%0d got=%0b want=%0b", i + 1, bus.commit_o, (i % 3) == 2); end
      tick();
    end
    #2;
    checks++; if (bus.retired_count_o !== 32'd4) begin failures++; $display("FAIL seq_retired got=%0d want=4", bus.retired_count_o); end
    checks++; if (bus.cycle_count_o !== 32'd12) begin failures++; $display("FAIL seq_cycles got=%0d want=12", bus.cycle_count_o); end
    checks++; if (bus.stall_count_o !== 32'd0) begin failures++; $display("FAIL seq_stalls got=%0d want=0", bus.stall_count_o); end
  endtask

  task automatic test_fetch_wait();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, i < 5, 1'b0, 1'b0, 32'h100);
      #2;
      checks++; if (bus.state_o !== FETCH) begin failures++; $display("FAIL fwait_state cyc=%0d got=%0d want=%0d", i, bus.state_o, FETCH); end
      checks++; if (bus.advance_o !== (i == 5)) begin failures++; $display("FAIL fwait_advance cyc=%0d got=%0b want=%0b", i, bus.advance_o, i == 5); end
      tick();
    end
    #2;
    checks++; if (bus.state_o !== EXEC1) begin failures++; $display("FAIL fwait_exec1 got=%0d want=%0d", bus.state_o, EXEC1); end
    checks++; if (bus.stall_count_o !== 32'd5) begin failures++; $display("FAIL fwait_stalls got=%0d want=5", bus.stall_count_o); end
  endtask

  task automatic test_muldiv();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    tick();
    for (int i = 0; i < 33; i++) begin
      drive(1'b0, 1'b1, 1'b0, i < 32, 32'h100);
      #2;
      checks++; if (bus.state_o !== EXEC1) begin failures++; $display("FAIL muldiv_state cyc=%0d got=%0d want=%0d", i, bus.state_o, EXEC1); end
      checks++; if (bus.fault_o !== 1'b0) begin failures++; $display("FAIL muldiv_fault cyc=%0d got=%0b want=0", i, bus.fault_o); end
      tick();
    end
    #2;
    checks++; if (bus.state_o !== EXEC2) begin failures++; $display("FAIL muldiv_exec2 got=%0d want=%0d", bus.state_o, EXEC2); end
    checks++; if (bus.stall_count_o !== 32'd32) begin failures++; $display("FAIL muldiv_stalls got=%0d want=32", bus.stall_count_o); end
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, HALT);
      #2;
      checks++; if (bus.commit_o !== (i == 2)) begin failures++; $display("FAIL halt_commit cyc=%0d got=%0b want=%0b", i, bus.commit_o, i == 2); end
      tick();
    end
    #2;
    checks++; if (bus.state_o !== HALTED) begin failures++; $display("FAIL halt_state got=%0d want=%0d", bus.state_o, HALTED); end
    checks++; if (bus.active_o !== 1'b0) begin failures++; $display("FAIL halt_active got=%0b want=0", bus.active_o); end
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      #2;
      checks++; if (bus.commit_o !== 1'b0 || bus.advance_o !== 1'b0) begin failures++; $display("FAIL halt_strobes cyc=%0d got=%0b%0b want=00", i, bus.commit_o, bus.advance_o); end
      checks++; if (bus.cycle_count_o !== 32'd3 || bus.retired_count_o !== 32'd1 || bus.stall_count_o !== 32'd0) begin
        failures++; $display("FAIL halt_frozen cyc=%0d got=%0d/%0d/%0d want=3/1/0", i, bus.cycle_count_o, bus.retired_count_o, bus.stall_count_o);
      end
      tick();
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h200);
      tick();
    end
    for (int i = 0; i < TO; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'h200);
      #2;
      checks++; if (bus.fault_o !== 1'b0 || bus.state_o !== FETCH) begin failures++; $display("FAIL wd_early cyc=%0d got=%0b/%0d want=0/%0d", i, bus.fault_o, bus.state_o, FETCH); end
      tick();
    end
    #2;
    checks++; if (bus.fault_o !== 1'b1) begin failures++; $display("FAIL wd_fault got=%0b want=1", bus.fault_o); end
    checks++; if (bus.state_o !== HALTED) begin failures++; $display("FAIL wd_state got=%0d want=%0d", bus.state_o, HALTED); end
    checks++; if (bus.retired_count_o !== 32'd1) begin failures++; $display("FAIL wd_retired got=%0d want=1", bus.retired_count_o); end
    checks++; if (bus.stall_count_o !== 32'd8) begin failures++; $display("FAIL wd_stalls got=%0d want=8", bus.stall_count_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h100);
    repeat (3) tick();
    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    #2;
    checks++; if (bus.state_o !== FETCH || bus.active_o !== 1'b0) begin failures++; $display("FAIL rmid_state got=%0d/%0b want=%0d/0", bus.state_o, bus.active_o, FETCH); end
    checks++; if (bus.cycle_count_o !== 32'd0 || bus.stall_count_o !== 32'd0 || bus.retired_count_o !== 32'd0) begin
      failures++; $display("FAIL rmid_counters got=%0d/%0d/%0d want=0/0/0", bus.cycle_count_o, bus.stall_count_o, bus.retired_count_o);
    end
    tick();
    #2;
    checks++; if (bus.active_o !== 1'b1) begin failures++; $display("FAIL rmid_active got=%0b want=1", bus.active_o); end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h100);
    repeat (TO) tick();
    #2;
    checks++; if (bus.fault_o !== 1'b1 || bus.state_o !== HALTED) begin failures++; $display("FAIL rhalt_pre got=%0b/%0d want=1/%0d", bus.fault_o, bus.state_o, HALTED); end
    drive(1'b1, 1'b1, 1'b0, 1'b0, 32'h100);
    tick();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h100);
    #2;
    checks++; if (bus.fault_o !== 1'b0 || bus.state_o !== FETCH) begin failures++; $display("FAIL rhalt_state got=%0b/%0d want=0/%0d", bus.fault_o, bus.state_o, FETCH); end
    checks++; if (bus.cycle_count_o !== 32'd0 || bus.stall_count_o !== 32'd0) begin failures++; $display("FAIL rhalt_counters got=%0d/%0d want=0/0", bus.cycle_count_o, bus.stall_count_o); end
    tick();
    #2;
    checks++; if (bus.active_o !== 1'b1) begin failures++; $display("FAIL rhalt_active got=%0b want=1", bus.active_o); end
  endtask

  task automatic test_random();
    int          burst = 0;
    bit          r;
    bit          wr;
    logic [31:0] pc;
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (burst == 0 && $urandom_range(0, 59) == 0) burst = $urandom_range(3, 12);
      wr = (burst > 0) || ($urandom_range(0, 3) == 0);
      if (burst > 0) burst--;
      r  = ((m_state == HALTED) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 199) == 0);
      pc = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
      drive(r, wr, 1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), pc);
      #2;
      checks++; if (bus.state_o !== m_state) begin failures++; $display("FAIL rnd_state cyc=%0d got=%0d want=%0d", i, bus.state_o, m_state); end
      checks++; if (bus.advance_o !== m_adv() || bus.commit_o !== m_commit()) begin
        failures++; $display("FAIL rnd_strobes cyc=%0d got=%0b%0b want=%0b%0b", i, bus.advance_o, bus.commit_o, m_adv(), m_commit());
      end
      checks++; if (bus.active_o !== m_active || bus.fault_o !== m_fault) begin
        failures++; $display("FAIL rnd_flags cyc=%0d got=%0b%0b want=%0b%0b", i, bus.active_o, bus.fault_o, m_active, m_fault);
      end
      checks++; if (bus.cycle_count_o !== m_cyc || bus.stall_count_o !== m_stall || bus.retired_count_o !== m_ret) begin
        failures++; $display("FAIL rnd_counters cyc=%0d got=%0d/%0d/%0d want=%0d/%0d/%0d", i,
                             bus.cycle_count_o, bus.stall_count_o, bus.retired_count_o, m_cyc, m_stall, m_ret);
      end
      tick();
    end
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h100);
    test_reset();
    test_no_wait();
    test_fetch_wait();
    test_muldiv();
    test_halt();
    test_watchdog();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
